// File: rtl/mult_sched_pkg.sv
// Shared types and default parameters for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int N_DEF       = 8;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  idx,
    output logic                     valid
);

    localparam int IW = $clog2(NREQ);

    logic [IW:0]   cand_sum [NREQ];
    logic [IW-1:0] cand     [NREQ];

    // cand[gi] is the requester index examined at priority position gi
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi] = (cand_sum[gi] >= (IW+1)'(NREQ)) ?
                          IW'(cand_sum[gi] - (IW+1)'(NREQ)) : cand_sum[gi][IW-1:0];
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[cand[i]]) begin
                valid = 1'b1;
                idx   = cand[i];
            end
        end
        gnt = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ clients,
// with result capture, one-cycle acknowledge and a sticky watchdog error.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic [NREQ-1:0]              REQ,
    input  logic [NREQ-1:0][N-1:0]       OPA,
    input  logic [NREQ-1:0][N-1:0]       OPB,
    output logic [NREQ-1:0]              ACK,
    output logic [2*N-1:0]               RESULT,
    output logic                         ERR,
    output logic                         BUSY,
    output logic [$clog2(NREQ)-1:0]      GRANT_ID,
    output logic                         MUL_START,
    output logic [N-1:0]                 MUL_A,
    output logic [N-1:0]                 MUL_B,
    input  logic [2*N-1:0]               MUL_S,
    input  logic                         MUL_END
);

    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [NREQ-1:0] grant_oh_q, grant_oh_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [2*N-1:0]  result_q, result_d;
    logic            err_q, err_d;
    logic [N-1:0]    mul_a_q, mul_a_d;
    logic [N-1:0]    mul_b_q, mul_b_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [IW-1:0]   ptr_next;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (REQ),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign ptr_next = (grant_id_q == IW'(NREQ-1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        ack_d      = '0;
        result_d   = result_q;
        err_d      = err_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        wd_d       = wd_q;
        unique case (state_q)
            IDLE: begin
                // A MUL_END still high here is a stale completion; hold off
                if (arb_valid && !MUL_END) begin
                    mul_a_d    = OPA[arb_idx];
                    mul_b_d    = OPB[arb_idx];
                    grant_id_d = arb_idx;
                    grant_oh_d = arb_gnt;
                    wd_d       = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                if (MUL_END) begin
                    result_d = MUL_S;
                    ack_d    = grant_oh_q;
                    ptr_d    = ptr_next;
                    state_d  = DRAIN;
                end else if (wd_q == WW'(TIMEOUT-1)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    ack_d    = grant_oh_q;
                    ptr_d    = ptr_next;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (!MUL_END) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            ack_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            ack_q      <= ack_d;
            result_q   <= result_d;
            err_q      <= err_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            wd_q       <= wd_d;
        end
    end

    assign ACK       = ack_q;
    assign RESULT    = result_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q != IDLE);
    assign GRANT_ID  = grant_id_q;
    assign MUL_START = (state_q == RUN);
    assign MUL_A     = mul_a_q;
    assign MUL_B     = mul_b_q;

    a_ack_onehot: assert property (@(posedge CLOCK) disable iff (RESET) $onehot0(ack_q));
    a_start_run:  assert property (@(posedge CLOCK) disable iff (RESET)
                                   (state_q != RUN) |-> !MUL_START);
    a_ack_gap:    assert property (@(posedge CLOCK) disable iff (RESET)
                                   !((|ack_q) && $past(|ack_q)));

endmodule
